// File: rtl/l1_cache_dm.sv
// Direct-mapped, write-back, write-allocate L1 cache with 128-bit lines.
// The CPU-side wishbone slave is served from the local arrays; misses go to the memory-side master.
module l1_cache_dm #(
   parameter int unsigned SETS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [11:0]  cpu_adr,
   input  logic [127:0] cpu_dat_m,
   output logic [127:0] cpu_dat_s,
   input  logic [15:0]  cpu_sel,
   input  logic         cpu_we,
   input  logic         cpu_cyc,
   input  logic         cpu_stb,
   output logic         cpu_ack,
   output logic [11:0]  mem_adr,
   output logic [127:0] mem_dat_m,
   input  logic [127:0] mem_dat_s,
   output logic [15:0]  mem_sel,
   output logic         mem_we,
   output logic         mem_cyc,
   output logic         mem_stb,
   input  logic         mem_ack,
   input  logic         mem_rty
);

   localparam int unsigned IDX = $clog2(SETS);
   localparam int unsigned TAG = 12 - IDX;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StResp = 2'd1;
   localparam logic [1:0] StWb   = 2'd2;
   localparam logic [1:0] StFill = 2'd3;

   logic [127:0]    data_q [SETS];
   logic [TAG-1:0]  tag_q  [SETS];
   logic [SETS-1:0] valid_q, valid_d;
   logic [SETS-1:0] dirty_q, dirty_d;
   logic [1:0]      state_q, state_d;
   logic            rty_q, rty_d;
   logic [127:0]    cpu_dat_s_q, cpu_dat_s_d;

   logic [IDX-1:0]  idx;
   logic [TAG-1:0]  adr_tag;
   logic [127:0]    line;
   logic [127:0]    merged;
   logic            req;
   logic            hit;
   logic            data_we;
   logic            tag_we;
   logic [127:0]    data_wdat;

   assign idx     = cpu_adr[IDX-1:0];
   assign adr_tag = cpu_adr[11:IDX];
   assign line    = data_q[idx];
   assign req     = cpu_cyc & cpu_stb;
   assign hit     = req & valid_q[idx] & (tag_q[idx] == adr_tag);

   always_comb begin
      merged = line;
      for (int unsigned i = 0; i < 16; i++) begin
         if (cpu_sel[i]) merged[8*i +: 8] = cpu_dat_m[8*i +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      rty_d       = 1'b0;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      cpu_dat_s_d = cpu_dat_s_q;
      data_we     = 1'b0;
      tag_we      = 1'b0;
      data_wdat   = merged;
      unique case (state_q)
         StIdle: begin
            if (hit) begin
               state_d = StResp;
               if (cpu_we) begin
                  data_we      = 1'b1;
                  dirty_d[idx] = 1'b1;
               end else begin
                  cpu_dat_s_d = line;
               end
            end else if (req) begin
               state_d = (valid_q[idx] && dirty_q[idx]) ? StWb : StFill;
            end
         end
         StResp: state_d = StIdle;
         StWb: begin
            // While rty_q is set the strobe is low, so responses are not expected
            if (!rty_q) begin
               if (mem_ack) begin
                  dirty_d[idx] = 1'b0;
                  state_d      = StFill;
               end else if (mem_rty) begin
                  rty_d = 1'b1;
               end
            end
         end
         StFill: begin
            if (!rty_q) begin
               if (mem_ack) begin
                  data_we      = 1'b1;
                  tag_we       = 1'b1;
                  data_wdat    = mem_dat_s;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b0;
                  state_d      = StIdle;
               end else if (mem_rty) begin
                  rty_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rty_q       <= 1'b0;
         valid_q     <= '0;
         dirty_q     <= '0;
         cpu_dat_s_q <= '0;
      end else begin
         state_q     <= state_d;
         rty_q       <= rty_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         cpu_dat_s_q <= cpu_dat_s_d;
      end
   end

   // Array contents need no reset; valid_q guards them
   always_ff @(posedge clk) begin
      if (!rst && data_we) data_q[idx] <= data_wdat;
      if (!rst && tag_we)  tag_q[idx]  <= adr_tag;
   end

   always_comb begin
      cpu_ack   = (state_q == StResp);
      cpu_dat_s = cpu_dat_s_q;
      mem_stb   = ((state_q == StWb) || (state_q == StFill)) && !rty_q;
      mem_cyc   = mem_stb;
      mem_we    = mem_stb && (state_q == StWb);
      mem_sel   = mem_stb ? 16'hFFFF : 16'h0000;
      mem_adr   = 12'h000;
      mem_dat_m = '0;
      if (state_q == StWb) begin
         mem_adr   = {tag_q[idx], idx};
         mem_dat_m = line;
      end else if (state_q == StFill) begin
         mem_adr = cpu_adr;
      end
   end

endmodule

// File: tb/tb_l1_cache_dm.sv
// Directed bench for l1_cache_dm: fills, hits, write merge, eviction, retry and reset abort.
module tb_l1_cache_dm;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [11:0]  cpu_adr = '0;
   logic [127:0] cpu_dat_m = '0;
   logic [127:0] cpu_dat_s;
   logic [15:0]  cpu_sel = '0;
   logic         cpu_we = 1'b0;
   logic         cpu_cyc = 1'b0;
   logic         cpu_stb = 1'b0;
   logic         cpu_ack;
   logic [11:0]  mem_adr;
   logic [127:0] mem_dat_m;
   logic [127:0] mem_dat_s = '0;
   logic [15:0]  mem_sel;
   logic         mem_we;
   logic         mem_cyc;
   logic         mem_stb;
   logic         mem_ack = 1'b0;
   logic         mem_rty = 1'b0;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] LineA  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
   localparam logic [127:0] LineB  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
   localparam logic [127:0] LineC  = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
   localparam logic [127:0] LineD  = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
   localparam logic [127:0] WrDat  = 128'h11111111_11111111_11111111_1111BEEF;
   localparam logic [127:0] Merged = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADBEEF;

   always #5 clk = ~clk;

   l1_cache_dm #(.SETS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_adr   (cpu_adr),
      .cpu_dat_m (cpu_dat_m),
      .cpu_dat_s (cpu_dat_s),
      .cpu_sel   (cpu_sel),
      .cpu_we    (cpu_we),
      .cpu_cyc   (cpu_cyc),
      .cpu_stb   (cpu_stb),
      .cpu_ack   (cpu_ack),
      .mem_adr   (mem_adr),
      .mem_dat_m (mem_dat_m),
      .mem_dat_s (mem_dat_s),
      .mem_sel   (mem_sel),
      .mem_we    (mem_we),
      .mem_cyc   (mem_cyc),
      .mem_stb   (mem_stb),
      .mem_ack   (mem_ack),
      .mem_rty   (mem_rty)
   );

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_req(input logic [11:0] adr, input logic we, input logic [15:0] sel,
                          input logic [127:0] dat);
      cpu_adr   = adr;
      cpu_we    = we;
      cpu_sel   = sel;
      cpu_dat_m = dat;
      cpu_stb   = 1'b1;
      cpu_cyc   = 1'b1;
   endtask

   task automatic cpu_drop();
      cpu_stb = 1'b0;
      cpu_cyc = 1'b0;
      cpu_we  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got %b want 0", cpu_ack); end
      checks++; if ({mem_stb, mem_cyc, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_mem_ctl got %b want 000", {mem_stb, mem_cyc, mem_we}); end
      checks++; if (cpu_dat_s !== '0) begin errors++; $display("FAIL reset_cpu_dat_s got %h want 0", cpu_dat_s); end
      checks++; if (mem_adr !== 12'h000 || mem_dat_m !== '0) begin errors++; $display("FAIL reset_mem_bus got adr %h dat %h want 0", mem_adr, mem_dat_m); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill_miss();
      cpu_req(12'h010, 1'b0, 16'hFFFF, '0);
      tick();
      checks++; if ({mem_stb, mem_cyc, mem_we} !== 3'b110) begin errors++; $display("FAIL fill_ctl got %b want 110", {mem_stb, mem_cyc, mem_we}); end
      checks++; if (mem_adr !== 12'h010) begin errors++; $display("FAIL fill_adr got %h want 010", mem_adr); end
      checks++; if (mem_sel !== 16'hFFFF) begin errors++; $display("FAIL fill_sel got %h want FFFF", mem_sel); end
      mem_dat_s = LineA;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_stb !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL fill_done got stb %b ack %b want 0 0", mem_stb, cpu_ack); end
      tick();
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL fill_ack got %b want 1", cpu_ack); end
      checks++; if (cpu_dat_s !== LineA) begin errors++; $display("FAIL fill_data got %h want %h", cpu_dat_s, LineA); end
      cpu_drop();
      tick();
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL fill_ack_pulse got %b want 0", cpu_ack); end
   endtask

   task automatic test_read_hit();
      cpu_req(12'h010, 1'b0, 16'hFFFF, '0);
      tick();
      checks++; if (cpu_ack !== 1'b1 || mem_stb !== 1'b0) begin errors++; $display("FAIL hit_ack got ack %b stb %b want 1 0", cpu_ack, mem_stb); end
      checks++; if (cpu_dat_s !== LineA) begin errors++; $display("FAIL hit_data got %h want %h", cpu_dat_s, LineA); end
      cpu_drop();
      tick();
   endtask

   task automatic test_write_merge();
      cpu_req(12'h010, 1'b1, 16'h0003, WrDat);
      tick();
      checks++; if (cpu_ack !== 1'b1 || mem_stb !== 1'b0) begin errors++; $display("FAIL write_ack got ack %b stb %b want 1 0", cpu_ack, mem_stb); end
      cpu_drop();
      tick();
      cpu_req(12'h010, 1'b0, 16'hFFFF, '0);
      tick();
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL readback_ack got %b want 1", cpu_ack); end
      checks++; if (cpu_dat_s !== Merged) begin errors++; $display("FAIL readback_data got %h want %h", cpu_dat_s, Merged); end
      cpu_drop();
      tick();
   endtask

   task automatic test_evict();
      cpu_req(12'h018, 1'b0, 16'hFFFF, '0);
      tick();
      checks++; if ({mem_stb, mem_cyc, mem_we} !== 3'b111) begin errors++; $display("FAIL wb_ctl got %b want 111", {mem_stb, mem_cyc, mem_we}); end
      checks++; if (mem_adr !== 12'h010) begin errors++; $display("FAIL wb_adr got %h want 010", mem_adr); end
      checks++; if (mem_dat_m !== Merged) begin errors++; $display("FAIL wb_data got %h want %h", mem_dat_m, Merged); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wb_no_ack got %b want 0", cpu_ack); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++; if ({mem_stb, mem_we} !== 2'b10) begin errors++; $display("FAIL evict_fill_ctl got %b want 10", {mem_stb, mem_we}); end
      checks++; if (mem_adr !== 12'h018) begin errors++; $display("FAIL evict_fill_adr got %h want 018", mem_adr); end
      mem_dat_s = LineB;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      checks++; if (cpu_ack !== 1'b1 || cpu_dat_s !== LineB) begin errors++; $display("FAIL evict_resp got ack %b dat %h want 1 %h", cpu_ack, cpu_dat_s, LineB); end
      cpu_drop();
      tick();
   endtask

   task automatic test_retry();
      int acks = 0;
      cpu_req(12'h025, 1'b0, 16'hFFFF, '0);
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++; if (mem_stb !== 1'b1 || mem_adr !== 12'h025) begin errors++; $display("FAIL rty_issue%0d got stb %b adr %h want 1 025", i, mem_stb, mem_adr); end
         mem_rty = 1'b1;
         tick();
         mem_rty = 1'b0;
         checks++; if (mem_stb !== 1'b0 || mem_cyc !== 1'b0) begin errors++; $display("FAIL rty_drop%0d got stb %b cyc %b want 0 0", i, mem_stb, mem_cyc); end
         if (cpu_ack === 1'b1) acks++;
         tick();
      end
      checks++; if (mem_stb !== 1'b1) begin errors++; $display("FAIL rty_reissue got %b want 1", mem_stb); end
      // Ack and retry together: the ack must win
      mem_dat_s = LineC;
      mem_ack   = 1'b1;
      mem_rty   = 1'b1;
      tick();
      mem_ack = 1'b0;
      mem_rty = 1'b0;
      if (cpu_ack === 1'b1) acks++;
      tick();
      checks++; if (cpu_ack !== 1'b1 || cpu_dat_s !== LineC) begin errors++; $display("FAIL rty_resp got ack %b dat %h want 1 %h", cpu_ack, cpu_dat_s, LineC); end
      if (cpu_ack === 1'b1) acks++;
      cpu_drop();
      tick();
      if (cpu_ack === 1'b1) acks++;
      checks++; if (acks !== 1) begin errors++; $display("FAIL rty_single_ack got %0d want 1", acks); end
   endtask

   task automatic test_reset_mid_wb();
      cpu_req(12'h025, 1'b1, 16'h8000, 128'hEE00_0000_0000_0000_0000_0000_0000_0000);
      tick();
      cpu_drop();
      tick();
      cpu_req(12'h02D, 1'b0, 16'hFFFF, '0);
      tick();
      checks++; if ({mem_stb, mem_we} !== 2'b11 || mem_adr !== 12'h025) begin errors++; $display("FAIL abort_wb got ctl %b adr %h want 11 025", {mem_stb, mem_we}, mem_adr); end
      rst = 1'b1;
      cpu_drop();
      tick();
      rst = 1'b0;
      checks++; if ({mem_stb, mem_cyc, mem_we, cpu_ack} !== 4'b0000) begin errors++; $display("FAIL abort_idle got %b want 0000", {mem_stb, mem_cyc, mem_we, cpu_ack}); end
      cpu_req(12'h010, 1'b0, 16'hFFFF, '0);
      tick();
      checks++; if ({mem_stb, mem_we} !== 2'b10 || mem_adr !== 12'h010) begin errors++; $display("FAIL post_rst_fill got ctl %b adr %h want 10 010", {mem_stb, mem_we}, mem_adr); end
      mem_dat_s = LineA;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      checks++; if (cpu_ack !== 1'b1 || cpu_dat_s !== LineA) begin errors++; $display("FAIL post_rst_resp got ack %b dat %h want 1 %h", cpu_ack, cpu_dat_s, LineA); end
      cpu_drop();
      tick();
      // The line left dirty before reset must now miss cleanly
      cpu_req(12'h025, 1'b0, 16'hFFFF, '0);
      tick();
      checks++; if ({mem_stb, mem_we, cpu_ack} !== 3'b100 || mem_adr !== 12'h025) begin errors++; $display("FAIL post_rst_miss got ctl %b adr %h want 100 025", {mem_stb, mem_we, cpu_ack}, mem_adr); end
      mem_dat_s = LineD;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      checks++; if (cpu_ack !== 1'b1 || cpu_dat_s !== LineD) begin errors++; $display("FAIL post_rst_miss_resp got ack %b dat %h want 1 %h", cpu_ack, cpu_dat_s, LineD); end
      cpu_drop();
      tick();
   endtask

   initial begin
      test_reset();
      test_fill_miss();
      test_read_hit();
      test_write_merge();
      test_evict();
      test_retry();
      test_reset_mid_wb();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
